mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words of backing storage.
REQ-002 SHALL have parameter WAIT_STATES, default 2, range 0..15, giving the number of extra access cycles per request.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of word 0.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request accepted on this edge if req_valid is high.
REQ-008 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_address  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data.
REQ-011 SHALL have port req_byte_en  input  4  byte-lane enables; bit i selects bits 8i+7:8i.
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  response consumed on this edge if rsp_valid is high.
REQ-014 SHALL have port rsp_rdata  output  32  load data; zero for stores and errors.
REQ-015 SHALL have port rsp_error  output  1  request was misaligned or out of range.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS and RESPOND, with at most one request outstanding.
REQ-017 SHALL drive req_ready high only in IDLE, and SHALL capture write, address, wdata and byte_en on the accepting edge.
REQ-018 SHALL go from IDLE to ACCESS on acceptance, stay in ACCESS for exactly WAIT_STATES cycles (zero means one pass through), then go to RESPOND.
REQ-019 SHALL assert rsp_valid exactly 1+WAIT_STATES cycles after the accepting edge.
REQ-020 SHALL hold rsp_valid, rsp_rdata and rsp_error stable in RESPOND until rsp_ready is high, then return to IDLE; req_ready rises the following cycle.
REQ-021 SHALL flag an error when req_address[1:0] is not 0 or when the address lies outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
REQ-022 On error, SHALL leave storage unmodified and return rsp_rdata of 0.
REQ-023 SHALL commit a store on the ACCESS-to-RESPOND edge, writing only the enabled byte lanes.
REQ-024 SHALL treat a store with req_byte_en of 0 as a successful no-op with rsp_error 0.
REQ-025 SHALL return word contents for a load, with non-enabled lanes forced to zero.
REQ-026 SHALL return a load issued right after a store to the same word with the stored data (read-after-write coherent).
REQ-027 SHALL compute the word index as (req_address-BASE_ADDR)>>2, using 32-bit wrap-free comparison against the bounds.
REQ-028 SHALL keep rsp_rdata at 0 and rsp_error at 0 whenever rsp_valid is low.

Reset
REQ-029 While reset is high, SHALL hold state IDLE, req_ready 0, rsp_valid 0, rsp_rdata 0 and rsp_error 0; req_ready SHALL rise the first cycle after reset deasserts.
REQ-030 Reset mid-operation SHALL drop the pending request with no response, and any store not yet committed SHALL be discarded.
REQ-031 Storage contents SHALL NOT be reset.

Structure
REQ-032 SHALL place the FSM state enum and a request struct (write, address, wdata, byte_en) in shared package mem_pkg.
REQ-033 SHALL place storage in sub-module mem_array: a single-port synchronous RAM with per-byte write enables and one-cycle read.

Verification
REQ-034 Store then load: with WAIT_STATES=2, store 0xDEADBEEF to 0x10 with be=4'hF, then load 0x10 -> rsp_valid at +3 cycles each; rdata 0xDEADBEEF; error 0.
REQ-035 Partial store: over 0xDEADBEEF, store 0x000000AA to 0x10 with be=4'b0001, then load with be=4'hF -> 0xDEADBEAA.
REQ-036 Errors: load 0x12 -> error 1, rdata 0; store to 4*DEPTH_WORDS -> error 1 and a later load of the last word is unchanged.
REQ-037 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable and req_ready 0 throughout; req_ready 1 the cycle after the handshake.
REQ-038 Reset mid-store: assert reset during ACCESS of a store of 0x12345678 to 0x20 -> no response; a later load of 0x20 returns its prior value.
REQ-039 Zero wait: with WAIT_STATES=0, back-to-back loads with rsp_ready tied high -> one response per 3 cycles, each at +1 from acceptance.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory responder: FSM states, captured request and lane helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] address;
        logic [31:0] wdata;
        logic [3:0]  byte_en;
    } req_t;

    // Expand four byte-lane enables into a 32-bit data mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] mask;
        mask = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

    // Word-address width for a given depth, never narrower than one bit.
    function automatic int unsigned addr_bits(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with per-byte write enables and one-cycle read.
// Contents are intentionally not reset.
module mem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic          clock,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH_WORDS];
    logic [31:0] rdata_r;

    // Read-first access: write enabled lanes and register the old word contents.
    always_ff @(posedge clock) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one load/store, waits a fixed
// number of access cycles, then holds a response until it is consumed.
// Loads read the RAM on the accepting edge so data is ready even with zero
// wait states; stores commit on the ACCESS-to-RESPOND edge, so a reset during
// ACCESS discards them.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_byte_en,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int unsigned AW        = addr_bits(DEPTH_WORDS);
    localparam logic [32:0] LIMIT     = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_STATES);

    // Misaligned or outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS); the offset
    // is compared in 33 bits so the upper bound can never wrap.
    function automatic logic addr_bad(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ({1'b0, off} >= LIMIT);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

    state_t        state_r, state_s;
    req_t          req_r;
    logic [3:0]    cnt_r;
    logic          req_ready_r, rsp_valid_r, rsp_error_r;
    logic [31:0]   rsp_rdata_r;
    logic          accept_s, commit_s, cur_err_s;
    logic          ram_en_s;
    logic [3:0]    ram_we_s;
    logic [AW-1:0] ram_addr_s;
    logic [31:0]   ram_rdata_s;

    assign accept_s  = (state_r == IDLE) && req_valid;
    assign commit_s  = (state_r == ACCESS) && (cnt_r == WAIT_LAST);
    assign cur_err_s = addr_bad(req_r.address);

    // RAM port: load read on acceptance, store write on commit.
    always_comb begin
        ram_en_s   = 1'b0;
        ram_we_s   = 4'b0000;
        ram_addr_s = word_idx(req_r.address);
        if (accept_s) begin
            ram_addr_s = word_idx(req_address);
            ram_en_s   = !req_write && !addr_bad(req_address);
        end else if (commit_s && req_r.write && !cur_err_s) begin
            ram_en_s = 1'b1;
            ram_we_s = req_r.byte_en;
        end else begin
            ram_en_s = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = req_valid ? ACCESS : IDLE;
            ACCESS:  state_s = commit_s ? RESPOND : ACCESS;
            RESPOND: state_s = rsp_ready ? IDLE : RESPOND;
            default: state_s = IDLE;
        endcase
    end

    // State register and registered handshake flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            req_ready_r <= (state_s == IDLE);
            rsp_valid_r <= (state_s == RESPOND);
        end
    end

    // Request capture and access-cycle counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_r <= '0;
            cnt_r <= 4'd0;
        end else if (accept_s) begin
            req_r <= '{write: req_write, address: req_address,
                       wdata: req_wdata, byte_en: req_byte_en};
            cnt_r <= 4'd0;
        end else if ((state_r == ACCESS) && !commit_s) begin
            cnt_r <= cnt_r + 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Response payload: loaded on commit, held through RESPOND, zero otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_rdata_r <= 32'h0000_0000;
            rsp_error_r <= 1'b0;
        end else if (commit_s) begin
            rsp_error_r <= cur_err_s;
            rsp_rdata_r <= (cur_err_s || req_r.write) ? 32'h0000_0000
                                                      : (ram_rdata_s & lane_mask(req_r.byte_en));
        end else if ((state_r == RESPOND) && rsp_ready) begin
            rsp_rdata_r <= 32'h0000_0000;
            rsp_error_r <= 1'b0;
        end else begin
            rsp_rdata_r <= rsp_rdata_r;
        end
    end

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_mem_array (
        .clock(clock),
        .en   (ram_en_s),
        .we   (ram_we_s),
        .addr (ram_addr_s),
        .wdata(req_r.wdata),
        .rdata(ram_rdata_s)
    );

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_error = rsp_error_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a vector table on a WAIT_STATES=2 instance,
// plus backpressure, reset-during-store and zero-wait throughput sequences.
module tb_mem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_error;
    logic [31:0] req_address, req_wdata, rsp_rdata;
    logic [3:0]  req_byte_en;
    logic        req_valid_z, req_ready_z, req_write_z, rsp_valid_z, rsp_ready_z, rsp_error_z;
    logic [31:0] req_address_z, req_wdata_z, rsp_rdata_z;
    logic [3:0]  req_byte_en_z;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2), .BASE_ADDR(32'h0000_0000)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata), .req_byte_en(req_byte_en),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
    );

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0000)) dut0 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
        .req_address(req_address_z), .req_wdata(req_wdata_z), .req_byte_en(req_byte_en_z),
        .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_rdata(rsp_rdata_z), .rsp_error(rsp_error_z)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete transaction on the W=2 instance; starts and ends #1 after an edge.
    task automatic run_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, output logic [31:0] rd, output logic er,
                           output int lat);
        int guard;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clock); #1; guard++;
        end
        check("req_ready_before", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_address = a; req_wdata = d; req_byte_en = be;
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clock); #1; lat++;
        end
        rd = rsp_rdata;
        er = rsp_error;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        check("req_ready_after_hs", {31'd0, req_ready}, 32'd1);
        check("rsp_valid_after_hs", {31'd0, rsp_valid}, 32'd0);
        check("rdata_zero_idle", rsp_rdata, 32'h0000_0000);
    endtask

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[15];
    vec_t        zreq[4];
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          acc[4], rsp[4];
    logic [31:0] zrd[4];
    logic        zer[4];
    int          k, r;
    logic        rdy, seen;

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0010, 32'h0000_00AA, 4'h1, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEAA, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h6, 32'h00AD_BE00, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0012, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b1, 32'h0000_0FFC, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 4'hF, 32'h1122_3344, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEAA, 1'b0};
        vecs[11] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 4'hF, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b1, 32'h0000_0020, 32'h5555_5555, 4'hF, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b0, 32'h0000_0013, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
        vecs[14] = '{1'b0, 32'h0000_1000, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};

        zreq[0] = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 4'hF, 32'h0000_0000, 1'b0};
        zreq[1] = '{1'b1, 32'h0000_0004, 32'h0F0F_0F0F, 4'hF, 32'h0000_0000, 1'b0};
        zreq[2] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'hF, 32'hA5A5_A5A5, 1'b0};
        zreq[3] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 4'hF, 32'h0F0F_0F0F, 1'b0};

        req_valid = 1'b0; req_write = 1'b0; req_address = 32'h0; req_wdata = 32'h0;
        req_byte_en = 4'h0; rsp_ready = 1'b0;
        req_valid_z = 1'b0; req_write_z = 1'b0; req_address_z = 32'h0; req_wdata_z = 32'h0;
        req_byte_en_z = 4'h0; rsp_ready_z = 1'b1;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0000_0000);
        check("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
        check("rst_req_ready_z", {31'd0, req_ready_z}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check("req_ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Vector table
        for (int i = 0; i < 15; i++) begin
            run_req(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_error", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
        end

        // Backpressure: response held for 5 cycles
        req_valid = 1'b1; req_write = 1'b0; req_address = 32'h0000_0010; req_byte_en = 4'hF;
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clock); #1; lat++;
        end
        check("bp_latency", 32'(lat), 32'd3);
        for (int c = 0; c < 5; c++) begin
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_rdata", rsp_rdata, 32'hDEAD_BEAA);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clock); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        check("bp_req_ready_after", {31'd0, req_ready}, 32'd1);

        // Reset during ACCESS of a store: no response, store discarded
        req_valid = 1'b1; req_write = 1'b1; req_address = 32'h0000_0020;
        req_wdata = 32'h1234_5678; req_byte_en = 4'hF;
        @(posedge clock); #1;
        req_valid = 1'b0;
        check("rs_in_access", {31'd0, rsp_valid}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rs_req_ready_in_rst", {31'd0, req_ready}, 32'd0);
        check("rs_rsp_valid_in_rst", {31'd0, rsp_valid}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("rs_no_response", {31'd0, seen}, 32'd0);
        run_req(1'b0, 32'h0000_0020, 32'h0, 4'hF, rd, er, lat);
        check("rs_prior_value", rd, 32'h5555_5555);
        check("rs_prior_error", {31'd0, er}, 32'd0);

        // Zero wait states, rsp_ready high, back-to-back requests
        k = 0; r = 0;
        for (int i = 0; i < 4; i++) begin
            acc[i] = 0; rsp[i] = 0; zrd[i] = 32'h0; zer[i] = 1'b1;
        end
        req_valid_z = 1'b1; req_write_z = zreq[0].write; req_address_z = zreq[0].addr;
        req_wdata_z = zreq[0].wdata; req_byte_en_z = zreq[0].be;
        rdy = req_ready_z;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clock); #1;
            if (rdy && req_valid_z && k < 4) begin
                acc[k] = cyc;
                k++;
                if (k < 4) begin
                    req_write_z = zreq[k].write; req_address_z = zreq[k].addr;
                    req_wdata_z = zreq[k].wdata; req_byte_en_z = zreq[k].be;
                end else begin
                    req_valid_z = 1'b0;
                end
            end
            if (rsp_valid_z && r < 4) begin
                rsp[r] = cyc; zrd[r] = rsp_rdata_z; zer[r] = rsp_error_z;
                r++;
            end
            rdy = req_ready_z;
        end
        check("z_accepts", 32'(k), 32'd4);
        check("z_responses", 32'(r), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("z%0d_latency", i), 32'(rsp[i] - acc[i]), 32'd1);
            check($sformatf("z%0d_rdata", i), zrd[i], zreq[i].exp_rdata);
            check($sformatf("z%0d_error", i), {31'd0, zer[i]}, 32'd0);
            if (i > 0) check($sformatf("z%0d_spacing", i), 32'(acc[i] - acc[i-1]), 32'd3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
